uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit blocks.
// Optional packet lock in the arbiter is enabled with UART_ARB_LOCK_EN.
package uart_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int CLK_FREQ   = 50_000_000;
   localparam int BAUD_RATE  = 115_200;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_e;

   function automatic int baud_div();
      return CLK_FREQ / BAUD_RATE;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: search starts just after last_grant and wraps.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   always_comb begin : sel
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int off = 1; off <= N; off++) begin
         idx = int'(last_grant) + off;
         if (idx >= N) idx = idx - N;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources, one byte per frame.
// Define UART_ARB_LOCK_EN to hold the grant on one requester until req_last.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]    req_data,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         tx_start,
   output logic [DATA_W-1:0]            tx_data,
   input  logic                         tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         grant_valid
);

   localparam int IW = $clog2(NUM_REQ);

   arb_state_e         state_q, state_d;
   logic               tx_start_q, tx_start_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic [IW-1:0]      grant_id_q, grant_id_d;
   logic               grant_valid_q, grant_valid_d;
   logic [IW-1:0]      last_grant_q, last_grant_d;

   logic [NUM_REQ-1:0] arb_req;
   logic [NUM_REQ-1:0] arb_grant;
   logic [IW-1:0]      arb_idx;
   logic               arb_any;
   logic               accept;

`ifdef UART_ARB_LOCK_EN
   logic               lock_q, lock_d;
   logic [IW-1:0]      lock_id_q, lock_id_d;

   // While a packet is open only its owner may win the next slot.
   assign arb_req = lock_q ? (req_valid & (NUM_REQ'(1) << lock_id_q))
                           : req_valid;
`else
   logic               unused_last;

   assign arb_req     = req_valid;
   assign unused_last = ^req_last;
`endif

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr (
      .req        (arb_req),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .grant_idx  (arb_idx),
      .any        (arb_any)
   );

   // An external sender holding tx_busy in IDLE also blocks acceptance.
   assign accept = rst && (state_q == IDLE) && !tx_busy && arb_any;

   always_comb begin
      state_d       = state_q;
      tx_start_d    = 1'b0;
      tx_data_d     = tx_data_q;
      grant_id_d    = grant_id_q;
      grant_valid_d = grant_valid_q;
      last_grant_d  = last_grant_q;
      req_ready     = '0;
`ifdef UART_ARB_LOCK_EN
      lock_d        = lock_q;
      lock_id_d     = lock_id_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               req_ready     = arb_grant;
               tx_data_d     = req_data[arb_idx*DATA_W +: DATA_W];
               grant_id_d    = arb_idx;
               grant_valid_d = 1'b1;
               last_grant_d  = arb_idx;
               tx_start_d    = 1'b1;
               state_d       = START;
`ifdef UART_ARB_LOCK_EN
               lock_d        = !req_last[arb_idx];
               lock_id_d     = arb_idx;
`endif
            end
         end
         START: begin
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_d       = IDLE;
               grant_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         last_grant_q  <= IW'(NUM_REQ - 1);
`ifdef UART_ARB_LOCK_EN
         lock_q        <= 1'b0;
         lock_id_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         tx_start_q    <= tx_start_d;
         tx_data_q     <= tx_data_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
         last_grant_q  <= last_grant_d;
`ifdef UART_ARB_LOCK_EN
         lock_q        <= lock_d;
         lock_id_q     <= lock_id_d;
`endif
      end
   end

   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign grant_id    = grant_id_q;
   assign grant_valid = grant_valid_q;

endmodule
